// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue path: FSM encoding,
// default timeout, and the RV32M opcode fields also used by the decoder.
package md_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } md_state_e;

    localparam int TIMEOUT_DEF = 64;
    localparam int CNT_W_DEF   = 7;

    // RV32M lives in the OP major opcode with funct7 = 0000001.
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] F7_MULDIV   = 7'b0000001;
    localparam logic [2:0] F3_MUL      = 3'b000;
    localparam logic [2:0] F3_MULH     = 3'b001;
    localparam logic [2:0] F3_MULHSU   = 3'b010;
    localparam logic [2:0] F3_MULHU    = 3'b011;
    localparam logic [2:0] F3_DIV      = 3'b100;
    localparam logic [2:0] F3_DIVU     = 3'b101;
    localparam logic [2:0] F3_REM      = 3'b110;
    localparam logic [2:0] F3_REMU     = 3'b111;

    function automatic logic is_muldiv(input logic [6:0] opc,
                                       input logic [6:0] f7);
        return (opc == OPC_OP) && (f7 == F7_MULDIV);
    endfunction

    // funct3[2] separates the divide/remainder group from multiplies.
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/md_wait_counter.sv
// Wait-cycle counter for the mult/div handshake.
// Ports: i_clock, i_reset (async high), i_clr (sync clear), i_en (count),
//        o_terminal (count has reached TIMEOUT-1).
module md_wait_counter #(
    parameter int CNT_W   = 7,
    parameter int TIMEOUT = 64
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_terminal
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_terminal = (r_cnt == LAST);

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Execute-stage initiator for the iterative multiplier/divider: latches
// operands, pulses ctrl_MULT/ctrl_DIV, stalls until the unit answers (or a
// timeout), then strobes the captured result for writeback.
// Ports: clock/reset; issue_* from decode; flush squashes the op;
//        ctrl_*/md_operand* to units; md_* results back; stall to pipeline;
//        wb_* writeback strobe, destination, data and exception.
module multdiv_issue_ctrl
    import md_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [31:0] issue_opA,
    input  logic [31:0] issue_opB,
    input  logic [4:0]  issue_rd,
    input  logic        flush,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception
);

    md_state_e   r_state;
    logic [4:0]  r_rd;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic        r_ctrl_mult;
    logic        r_ctrl_div;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_wb_exc;

    logic w_accept;
    logic w_cnt_clr;
    logic w_cnt_en;
    logic w_term;

    assign w_accept  = (r_state == S_IDLE) & issue_valid & ~flush;
    assign w_cnt_clr = (r_state == S_START);
    assign w_cnt_en  = (r_state == S_WAIT);

    md_wait_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_cnt (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_clr      (w_cnt_clr),
        .i_en       (w_cnt_en),
        .o_terminal (w_term)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rd        <= '0;
            r_opA       <= '0;
            r_opB       <= '0;
            r_ctrl_mult <= 1'b0;
            r_ctrl_div  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_wb_exc    <= 1'b0;
        end else begin
            r_ctrl_mult <= 1'b0;
            r_ctrl_div  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_opA       <= issue_opA;
                        r_opB       <= issue_opB;
                        r_rd        <= issue_rd;
                        r_ctrl_div  <= issue_is_div;
                        r_ctrl_mult <= ~issue_is_div;
                        r_state     <= S_START;
                    end
                end
                // RDY is not looked at here: it may still be left over
                // from the previous operation.
                S_START: begin
                    r_state <= flush ? S_IDLE : S_WAIT;
                end
                // RDY has priority over the timeout so real data wins.
                S_WAIT: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (md_resultRDY) begin
                        r_wb_data <= md_result;
                        r_wb_exc  <= md_exception;
                        r_wb_rd   <= r_rd;
                        r_state   <= S_DONE;
                    end else if (w_term) begin
                        r_wb_data <= '0;
                        r_wb_exc  <= 1'b1;
                        r_wb_rd   <= r_rd;
                        r_state   <= S_DONE;
                    end
                end
                // The held instruction is still visible here; it must
                // not be accepted again.
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ctrl_MULT    = r_ctrl_mult;
    assign ctrl_DIV     = r_ctrl_div;
    assign md_operandA  = r_opA;
    assign md_operandB  = r_opB;
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign wb_exception = r_wb_exc;

    assign stall = ~reset &
                   (w_accept | (r_state == S_START) | (r_state == S_WAIT));

    assign wb_valid = (r_state == S_DONE) & ~flush;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Randomised + directed bench for multdiv_issue_ctrl with a cycle-offset
// reference model and an emulated mult/div unit.
module tb_multdiv_issue_ctrl;

    localparam int TO = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_is_div;
    logic [31:0] issue_opA;
    logic [31:0] issue_opB;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;

    always #5 clock = ~clock;

    multdiv_issue_ctrl #(.TIMEOUT(TO), .CNT_W(7)) dut (
        .clock        (clock),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_is_div (issue_is_div),
        .issue_opA    (issue_opA),
        .issue_opB    (issue_opB),
        .issue_rd     (issue_rd),
        .flush        (flush),
        .ctrl_MULT    (ctrl_MULT),
        .ctrl_DIV     (ctrl_DIV),
        .md_operandA  (md_operandA),
        .md_operandB  (md_operandB),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_resultRDY (md_resultRDY),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_exception (wb_exception)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference model: an op is tracked by its cycle offset k from the
    // accept cycle (k=1 pulse, k>=2 waiting, answer or k=TO+1 ends it).
    bit          m_busy = 0;
    bit          m_fin = 0;
    int          m_k = 0;
    bit          m_div = 0;
    logic [4:0]  m_rd = '0;
    logic [31:0] e_a = '0;
    logic [31:0] e_b = '0;
    logic [31:0] e_wbd = '0;
    logic        e_wbx = 1'b0;
    logic [4:0]  e_wbrd = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_busy = 0; m_fin = 0; m_k = 0;
            e_a = '0; e_b = '0; e_wbd = '0; e_wbx = 1'b0; e_wbrd = '0;
        end else if (m_fin) begin
            m_fin = 0;
        end else if (!m_busy) begin
            if (issue_valid && !flush) begin
                m_busy = 1; m_k = 1; m_div = issue_is_div;
                e_a = issue_opA; e_b = issue_opB; m_rd = issue_rd;
            end
        end else if (flush) begin
            m_busy = 0;
        end else if (m_k >= 2 && md_resultRDY) begin
            e_wbd = md_result; e_wbx = md_exception; e_wbrd = m_rd;
            m_busy = 0; m_fin = 1;
        end else if (m_k >= TO + 1) begin
            e_wbd = '0; e_wbx = 1'b1; e_wbrd = m_rd;
            m_busy = 0; m_fin = 1;
        end else begin
            m_k++;
        end
    end

    // Observation counters for the directed scenarios.
    int          n_wb, n_stall, n_mult, n_div, n_opbad;
    logic [31:0] l_wbd;
    logic        l_wbx;
    logic [4:0]  l_wbrd;
    logic [31:0] h_a, h_b;

    always @(negedge clock) begin
        logic x_stall, x_cm, x_cd, x_wbv;
        x_stall = !reset && (m_busy || (!m_fin && issue_valid && !flush));
        x_cm    = !reset && m_busy && (m_k == 1) && !m_div;
        x_cd    = !reset && m_busy && (m_k == 1) && m_div;
        x_wbv   = !reset && m_fin && !flush;
        chk("stall", 32'(stall), 32'(x_stall));
        chk("ctrl_MULT", 32'(ctrl_MULT), 32'(x_cm));
        chk("ctrl_DIV", 32'(ctrl_DIV), 32'(x_cd));
        chk("wb_valid", 32'(wb_valid), 32'(x_wbv));
        chk("wb_data", wb_data, reset ? 32'd0 : e_wbd);
        chk("wb_exception", 32'(wb_exception), reset ? 32'd0 : 32'(e_wbx));
        chk("wb_rd", 32'(wb_rd), reset ? 32'd0 : 32'(e_wbrd));
        chk("md_operandA", md_operandA, reset ? 32'd0 : e_a);
        chk("md_operandB", md_operandB, reset ? 32'd0 : e_b);
        if (wb_valid) begin
            n_wb++; l_wbd = wb_data; l_wbx = wb_exception; l_wbrd = wb_rd;
        end
        if (stall) n_stall++;
        if (ctrl_MULT) n_mult++;
        if (ctrl_DIV) n_div++;
        if (stall && m_busy && !reset &&
            (md_operandA !== h_a || md_operandB !== h_b)) n_opbad++;
    end

    // Emulated unit: answers rsp_delay cycles after the start pulse
    // (0 = never); rsp_stale forces RDY high around the issue.
    int          rsp_delay = 0;
    bit          rsp_stale = 0;
    int          r_cnt = 0;
    bit          r_div = 0;
    logic [31:0] r_a = '0, r_b = '0;

    initial begin
        md_resultRDY = 1'b0; md_result = '0; md_exception = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) r_cnt = 0;
            else if (ctrl_MULT || ctrl_DIV) begin
                r_cnt = rsp_delay; r_div = ctrl_DIV;
                r_a = md_operandA; r_b = md_operandB;
            end
            @(posedge clock);
            #2;
            md_resultRDY = rsp_stale;
            md_exception = 1'b0;
            md_result    = $urandom;
            if (r_cnt > 0) begin
                r_cnt--;
                if (r_cnt == 0) begin
                    md_resultRDY = 1'b1;
                    if (!r_div) md_result = r_a * r_b;
                    else if (r_b == 0) begin
                        md_exception = 1'b1; md_result = 32'hFFFF_FFFF;
                    end else if (r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF)
                        md_result = r_a;
                    else md_result = $signed(r_a) / $signed(r_b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_obs();
        n_wb = 0; n_stall = 0; n_mult = 0; n_div = 0; n_opbad = 0;
        l_wbd = '0; l_wbx = 1'b0; l_wbrd = '0;
    endtask

    task automatic idle(input int n);
        issue_valid = 1'b0; flush = 1'b0;
        repeat (n) tick();
    endtask

    // Issue one op (caller is one cycle after a posedge) and hold it
    // while stalled; flush_at = cycle offset to flush, -1 for none.
    task automatic run_op(input bit div, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input int d, input bit stale, input int flush_at,
                          input bit done_flush);
        int  j;
        bit  fin;
        rsp_delay = d; h_a = a; h_b = b;
        issue_is_div = div; issue_opA = a; issue_opB = b; issue_rd = rd;
        issue_valid = 1'b1; flush = 1'b0; rsp_stale = stale;
        j = 0; fin = 0;
        while (!fin) begin
            tick(); j++;
            if (j == 2) rsp_stale = 0;
            if (flush) begin
                flush = 1'b0; issue_valid = 1'b0; fin = 1;
            end else if (!stall) begin
                flush = done_flush;
                tick();
                flush = 1'b0; issue_valid = 1'b0; fin = 1;
            end else if (j == flush_at) begin
                flush = 1'b1;
            end else if (j > 300) begin
                checks++; errors++;
                $display("FAIL op_bound: op still stalled after %0d cycles", j);
                issue_valid = 1'b0; fin = 1;
            end
        end
        rsp_stale = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; issue_valid = 1'b1; issue_is_div = 1'b0;
        issue_opA = 32'd1; issue_opB = 32'd2; issue_rd = 5'd1; flush = 1'b0;
        h_a = '0; h_b = '0;
        clr_obs();
        repeat (3) tick();
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_wbdata", wb_data, 32'd0);
        issue_valid = 1'b0; reset = 1'b0;
        idle(2);

        clr_obs();
        run_op(1, 32'd100, 32'd7, 5'd9, 33, 0, -1, 0);
        idle(3);
        chk("div_pulse", 32'(n_div), 32'd1);
        chk("div_nomult", 32'(n_mult), 32'd0);
        chk("div_stall35", 32'(n_stall), 32'd35);
        chk("div_wbcount", 32'(n_wb), 32'd1);
        chk("div_data", l_wbd, 32'd14);
        chk("div_exc", 32'(l_wbx), 32'd0);
        chk("div_rd", 32'(l_wbrd), 32'd9);

        clr_obs();
        run_op(0, 32'hFFFF_FFFD, 32'd5, 5'd3, 16, 0, -1, 0);
        idle(3);
        chk("mul_pulse", 32'(n_mult), 32'd1);
        chk("mul_nodiv", 32'(n_div), 32'd0);
        chk("mul_data", l_wbd, 32'hFFFF_FFF1);
        chk("mul_stall", 32'(n_stall), 32'd18);

        clr_obs();
        run_op(1, 32'd5, 32'd0, 5'd12, 8, 0, -1, 0);
        idle(3);
        chk("dz_exc", 32'(l_wbx), 32'd1);
        chk("dz_wbcount", 32'(n_wb), 32'd1);
        chk("dz_opheld", 32'(n_opbad), 32'd0);

        clr_obs();
        run_op(0, 32'd6, 32'd7, 5'd4, 10, 1, -1, 0);
        idle(3);
        chk("stale_stall", 32'(n_stall), 32'd12);
        chk("stale_wbcount", 32'(n_wb), 32'd1);
        chk("stale_data", l_wbd, 32'd42);

        clr_obs();
        run_op(1, 32'd50, 32'd5, 5'd6, 10, 0, 6, 0);
        idle(15);
        chk("flush_nowb", 32'(n_wb), 32'd0);
        chk("flush_stall", 32'(n_stall), 32'd7);

        clr_obs();
        issue_valid = 1'b1; flush = 1'b1; issue_is_div = 1'b1;
        repeat (2) tick();
        idle(2);
        chk("blocked_stall", 32'(n_stall), 32'd0);
        chk("blocked_pulse", 32'(n_div + n_mult), 32'd0);

        clr_obs();
        run_op(1, 32'd9, 32'd3, 5'd21, 0, 0, -1, 0);
        idle(2);
        chk("to_stall", 32'(n_stall), 32'd66);
        chk("to_wbcount", 32'(n_wb), 32'd1);
        chk("to_data", l_wbd, 32'd0);
        chk("to_exc", 32'(l_wbx), 32'd1);
        chk("to_rd", 32'(l_wbrd), 32'd21);

        rsp_delay = 0;
        issue_is_div = 1'b0; issue_opA = 32'd123; issue_opB = 32'd456;
        issue_rd = 5'd7; issue_valid = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_exc", 32'(wb_exception), 32'd0);
        chk("rst_rd", 32'(wb_rd), 32'd0);
        chk("rst_opA", md_operandA, 32'd0);
        chk("rst_opB", md_operandB, 32'd0);
        repeat (2) tick();
        issue_valid = 1'b0; reset = 1'b0;
        idle(2);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            int d, fa;
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            d = ($urandom_range(0, 14) == 0) ? 0 : $urandom_range(1, 20);
            fa = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : -1;
            run_op(1'($urandom_range(0, 1)), a, b, 5'($urandom_range(0, 31)),
                   d, ($urandom_range(0, 3) == 0), fa,
                   ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) begin
                issue_valid = 1'b1; flush = 1'b1;
                tick();
            end
            idle($urandom_range(0, 3));
        end
        idle(25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
